ifns_rx_word_packer: RTL and testbench
======================================

// Module: ifns_rx_word_packer
// PURPOSE
//  Stage directly downstream of the 11-bit IFNS decoder. Takes the decoder's registered
//  8-bit data output and packs consecutive bytes LSB-first into BYTES-byte words.
//  Presents each word on a valid/ready interface. The decoder has no stall input, so
//  the block throttles the codeword source through code_ready.
// PARAMETERS
//  BYTES  4  bytes per output word; legal range 2..16; word width = 8*BYTES
// PORTS
//  clock       in   1        single clock, rising edge
//  rst_n       in   1        asynchronous reset, active low
//  code_valid  in   1        codeword presented to decoder this cycle (same cycle as codein)
//  dataout     in   8        decoder registered output; valid one cycle after code_valid
//  code_ready  out  1        source may assert code_valid only while high
//  word_out    out  8*BYTES  packed word; byte k at [8k+7:8k]
//  word_valid  out  1        word_out holds an unconsumed word
//  word_ready  in   1        consumer accepts word when word_valid & word_ready
//  overflow    out  1        sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset values: v_d=0, cnt=0, acc=0, word_out=0, word_valid=0, overflow=0. code_ready
//    resolves to 1. Reset is asynchronous and may assert at any time. A partial word in
//    progress is discarded.
//  - v_d registers code_valid. The block accepts dataout in every cycle with v_d=1, so
//    input-to-byte latency matches the decoder's 1 cycle.
//  - Accepted byte goes to acc[8*cnt+7 : 8*cnt]; cnt increments by 1.
//  - Word completion: accepted byte while cnt==BYTES-1. The completed word is
//    {dataout, acc[8*BYTES-9:0]}. cnt returns to 0 and acc returns to 0.
//  - Output slot is a single register. Slot is free when word_valid==0 or
//    (word_valid & word_ready) this cycle.
//  - On completion with a free slot: next cycle word_out = completed word and
//    word_valid = 1. This includes back-to-back completion in the same cycle as a
//    drain, with no bubble.
//  - On completion with a busy slot: word is dropped, overflow<=1 (sticky until reset),
//    and word_out stays unchanged. Reachable only by protocol violation.
//  - Drain without completion: word_valid<=0; word_out holds its last value.
//  - code_ready = ~(word_valid & (cnt + v_d >= BYTES-1)). Registers only, no
//    combinational path from word_ready.
//  - Guarantee: if the source honours code_ready, overflow never sets for any
//    word_ready pattern.
//  - cnt width $clog2(BYTES)+1. No wrap beyond BYTES-1.
// CONFIGURATION
//  IFNS_PACK_FLUSH_EN defined:
//  - Adds port flush (in, 1): single-cycle pulse.
//  - Adds port word_bytes (out, $clog2(BYTES)+1): count of valid bytes in word_out.
//    Reset value 0.
//  - flush is latched into flush_pend.
//  - Flush with v_d=1 in the same cycle: the accepted byte is included before flushing.
//  - When flush_pend & cnt>0 & slot free: emit acc zero-padded above byte cnt-1,
//    word_bytes=cnt, cnt<=0, clear flush_pend.
//  - Flush with cnt==0: no-op, flush_pend cleared.
//  - Full words carry word_bytes=BYTES.
//  - code_ready additionally low while flush_pend & word_valid.
//  IFNS_PACK_FLUSH_EN undefined: no flush or word_bytes ports. A partial word is held
//  until completed.
// TESTING
//  1. BYTES=4, word_ready=1, code_valid 4 cycles, bench decoder model returns
//     0x11,0x22,0x33,0x44 -> word_out=0x44332211, word_valid=1 one cycle after 4th byte
//     accepted.
//  2. word_ready=0, continuous source honouring code_ready -> code_ready falls once
//     cnt+v_d>=3 with word_valid=1, overflow stays 0. Release word_ready -> second word
//     0x88776655 delivered intact.
//  3. word_ready=0, bench forces code_valid while code_ready=0 for 4 bytes -> overflow=1
//     and stays 1. word_out keeps first word.
//  4. Reset mid-word: 2 bytes accepted, pulse rst_n low asynchronously -> all outputs 0,
//     code_ready=1. Next 4 bytes 0xA1..0xA4 -> word_out=0xA4A3A2A1.
//  5. word_ready=1 steady, 8 bytes on consecutive cycles -> words on cycles N and N+4,
//     no dropped cycle, overflow=0.
//  6. IFNS_PACK_FLUSH_EN: bytes 0xAA,0xBB then flush pulse -> word_out=0x0000BBAA,
//     word_bytes=2, cnt=0. Flush with cnt=0 -> no word_valid.

Source files
------------

// File: rtl/ifns_rx_word_packer.sv
// ifns_rx_word_packer: packs registered IFNS decoder bytes LSB-first into BYTES-byte valid/ready words
//   clock, rst_n (async, active low); code_valid/code_ready throttle the codeword source;
//   dataout is the decoder byte, valid one cycle after code_valid; word_out/word_valid/word_ready
//   is the output handshake; overflow is sticky when a completed word is dropped.
//   IFNS_PACK_FLUSH_EN adds flush (in) and word_bytes (out) for emitting partial words.
module ifns_rx_word_packer #(
  parameter int BYTES = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   code_valid,
  input  logic [7:0]             dataout,
  output logic                   code_ready,
  output logic [8*BYTES-1:0]     word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
`ifdef IFNS_PACK_FLUSH_EN
  input  logic                   flush,
  output logic [$clog2(BYTES):0] word_bytes,
`endif
  output logic                   overflow
);
  localparam int CW = $clog2(BYTES) + 1;
  logic v_q, v_d, word_valid_q, word_valid_d, overflow_q, overflow_d, free, complete;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8*BYTES-1:0] acc_q, acc_d, word_q, word_d;
`ifdef IFNS_PACK_FLUSH_EN
  logic flush_pend_q, flush_pend_d, do_flush;
  logic [CW-1:0] bytes_q, bytes_d;
  assign word_bytes = bytes_q;
`endif
  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;
  assign free       = ~word_valid_q | word_ready;
  assign complete   = v_q & (cnt_q == CW'(BYTES - 1));
  // Registers only: stall early enough that the byte already in the decoder still fits.
`ifdef IFNS_PACK_FLUSH_EN
  assign code_ready = ~(word_valid_q & ((({1'b0, cnt_q} + {{CW{1'b0}}, v_q}) >= (CW+1)'(BYTES - 1)) | flush_pend_q));
  assign do_flush   = flush_pend_q & (cnt_q != '0) & free & ~complete;
`else
  assign code_ready = ~(word_valid_q & (({1'b0, cnt_q} + {{CW{1'b0}}, v_q}) >= (CW+1)'(BYTES - 1)));
`endif
  always_comb begin
    v_d          = code_valid;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    word_d       = word_q;
    word_valid_d = word_valid_q & ~word_ready;
    overflow_d   = overflow_q;
    if (v_q) begin
      acc_d[{cnt_q[CW-2:0], 3'b000} +: 8] = dataout;
      cnt_d = cnt_q + CW'(1);
    end
    if (complete) begin
      cnt_d = '0;
      acc_d = '0;
      if (free) begin
        word_d       = {dataout, acc_q[8*BYTES-9:0]};
        word_valid_d = 1'b1;
      end else
        overflow_d = 1'b1;
    end
`ifdef IFNS_PACK_FLUSH_EN
    bytes_d      = (complete & free) ? CW'(BYTES) : bytes_q;
    flush_pend_d = flush | (flush_pend_q & ~do_flush & (cnt_q != '0));
    // Partial word leaves as-is; a byte arriving in the same cycle starts the next word.
    if (do_flush) begin
      word_d       = acc_q;
      word_valid_d = 1'b1;
      bytes_d      = cnt_q;
      cnt_d        = CW'(v_q);
      acc_d        = '0;
      acc_d[7:0]   = v_q ? dataout : 8'h00;
    end
`endif
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      v_q          <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef IFNS_PACK_FLUSH_EN
      flush_pend_q <= 1'b0;
      bytes_q      <= '0;
`endif
    end else begin
      v_q          <= v_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
`ifdef IFNS_PACK_FLUSH_EN
      flush_pend_q <= flush_pend_d;
      bytes_q      <= bytes_d;
`endif
    end
  end
endmodule

// File: tb/tb_ifns_rx_word_packer.sv
// tb_ifns_rx_word_packer: directed self-checking bench for ifns_rx_word_packer (BYTES=4)
module tb_ifns_rx_word_packer;
  logic clock = 1'b0, rst_n = 1'b0, code_valid = 1'b0, word_ready = 1'b0;
  logic [7:0] code_byte = 8'h00, dataout = 8'h00;
  logic code_ready, word_valid, overflow;
  logic [31:0] word_out;
`ifdef IFNS_PACK_FLUSH_EN
  logic flush = 1'b0;
  logic [2:0] word_bytes;
`endif
  int checks = 0, failures = 0;
  ifns_rx_word_packer #(.BYTES(4)) dut (
    .clock(clock), .rst_n(rst_n), .code_valid(code_valid), .dataout(dataout),
    .code_ready(code_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready),
`ifdef IFNS_PACK_FLUSH_EN
    .flush(flush), .word_bytes(word_bytes),
`endif
    .overflow(overflow)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (code_valid) dataout <= code_byte;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0; code_valid = 1'b0;
    step; step;
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    do_reset;
    checks += 4;
    if (word_out !== 32'h0) begin failures++; $display("FAIL reset_word_out got=%h exp=%h", word_out, 32'h0); end
    if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (code_ready !== 1'b1) begin failures++; $display("FAIL reset_code_ready got=%b exp=1", code_ready); end
  endtask
  task automatic test_basic;
    logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin code_valid = 1'b1; code_byte = b[k]; step; end
    code_valid = 1'b0;
    checks++;
    if (word_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", word_valid); end
    step;
    checks += 2;
    if (word_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", word_valid); end
    if (word_out !== 32'h44332211) begin failures++; $display("FAIL basic_word got=%h exp=44332211", word_out); end
    step;
    checks++;
    if (word_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%b exp=0", word_valid); end
  endtask
  task automatic test_backpressure;
    logic [7:0] b[8] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h55, 8'h66, 8'h77, 8'h88};
    int idx = 0;
    word_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      code_valid = code_ready && idx < 8;
      if (code_valid) begin code_byte = b[idx]; idx++; end
      step;
    end
    code_valid = 1'b0;
    checks += 5;
    if (idx !== 7) begin failures++; $display("FAIL bp_sent got=%0d exp=7", idx); end
    if (code_ready !== 1'b0) begin failures++; $display("FAIL bp_code_ready got=%b exp=0", code_ready); end
    if (word_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", word_valid); end
    if (word_out !== 32'hC4C3C2C1) begin failures++; $display("FAIL bp_first_word got=%h exp=c4c3c2c1", word_out); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow got=%b exp=0", overflow); end
    word_ready = 1'b1;
    step;
    word_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      code_valid = code_ready && idx < 8;
      if (code_valid) begin code_byte = b[idx]; idx++; end
      step;
    end
    code_valid = 1'b0;
    checks += 3;
    if (word_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%b exp=1", word_valid); end
    if (word_out !== 32'h88776655) begin failures++; $display("FAIL bp_second_word got=%h exp=88776655", word_out); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow2 got=%b exp=0", overflow); end
  endtask
  task automatic test_overflow;
    logic [7:0] b[4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin code_valid = 1'b1; code_byte = b[k]; step; end
    code_valid = 1'b0;
    step; step; step;
    checks += 3;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    if (word_out !== 32'h88776655) begin failures++; $display("FAIL ovf_word_kept got=%h exp=88776655", word_out); end
    if (word_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", word_valid); end
    word_ready = 1'b1;
    step; step; step;
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask
  task automatic test_async_reset;
    logic [7:0] b[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    word_ready = 1'b1;
    code_valid = 1'b1; code_byte = 8'h5A; step;
    code_byte = 8'h5B; step;
    code_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks += 4;
    if (word_out !== 32'h0) begin failures++; $display("FAIL arst_word_out got=%h exp=0", word_out); end
    if (word_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", word_valid); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
    if (code_ready !== 1'b1) begin failures++; $display("FAIL arst_code_ready got=%b exp=1", code_ready); end
    step;
    #2 rst_n = 1'b1;
    step;
    for (int k = 0; k < 4; k++) begin code_valid = 1'b1; code_byte = b[k]; step; end
    code_valid = 1'b0;
    step;
    checks += 2;
    if (word_valid !== 1'b1) begin failures++; $display("FAIL arst_after_valid got=%b exp=1", word_valid); end
    if (word_out !== 32'hA4A3A2A1) begin failures++; $display("FAIL arst_after_word got=%h exp=a4a3a2a1", word_out); end
    step;
  endtask
  task automatic test_back_to_back;
    logic [7:0] b[8] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
    int nw = 0, t0 = -1, t1 = -1, rdy_low = 0;
    logic [31:0] w0 = '0, w1 = '0;
    word_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      code_valid = k < 8;
      code_byte = b[k % 8];
      step;
      if (!code_ready) rdy_low++;
      if (word_valid) begin
        if (nw == 0) begin t0 = k + 1; w0 = word_out; end
        else if (nw == 1) begin t1 = k + 1; w1 = word_out; end
        nw++;
      end
    end
    code_valid = 1'b0;
    checks += 7;
    if (nw !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nw); end
    if (t0 !== 5) begin failures++; $display("FAIL b2b_t0 got=%0d exp=5", t0); end
    if (t1 !== 9) begin failures++; $display("FAIL b2b_t1 got=%0d exp=9", t1); end
    if (w0 !== 32'hB4B3B2B1) begin failures++; $display("FAIL b2b_w0 got=%h exp=b4b3b2b1", w0); end
    if (w1 !== 32'hB8B7B6B5) begin failures++; $display("FAIL b2b_w1 got=%h exp=b8b7b6b5", w1); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    if (rdy_low !== 0) begin failures++; $display("FAIL b2b_code_ready_low got=%0d exp=0", rdy_low); end
  endtask
`ifdef IFNS_PACK_FLUSH_EN
  task automatic test_flush;
    logic [7:0] b[4] = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    int seen = 0, nv = 0;
    do_reset;
    word_ready = 1'b1;
    code_valid = 1'b1; code_byte = 8'hAA; step;
    code_byte = 8'hBB; step;
    code_valid = 1'b0; flush = 1'b1; step;
    flush = 1'b0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      step;
      if (word_valid) seen = 1;
    end
    checks += 3;
    if (seen !== 1) begin failures++; $display("FAIL flush_timeout got=%0d exp=1", seen); end
    if (word_out !== 32'h0000BBAA) begin failures++; $display("FAIL flush_word got=%h exp=0000bbaa", word_out); end
    if (word_bytes !== 3'd2) begin failures++; $display("FAIL flush_bytes got=%0d exp=2", word_bytes); end
    step;
    flush = 1'b1; step;
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin step; if (word_valid) nv++; end
    checks++;
    if (nv !== 0) begin failures++; $display("FAIL flush_empty got=%0d exp=0", nv); end
    for (int k = 0; k < 4; k++) begin code_valid = 1'b1; code_byte = b[k]; step; end
    code_valid = 1'b0;
    step;
    checks += 2;
    if (word_out !== 32'hE4E3E2E1) begin failures++; $display("FAIL flush_full_word got=%h exp=e4e3e2e1", word_out); end
    if (word_bytes !== 3'd4) begin failures++; $display("FAIL flush_full_bytes got=%0d exp=4", word_bytes); end
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_async_reset;
    test_back_to_back;
`ifdef IFNS_PACK_FLUSH_EN
    test_flush;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
